// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD definitions used by the BCD up- and down-counters.
//   BCD_W        width of one packed BCD digit
//   BCD_MAX      largest legal digit value (9)
//   BCD_ZERO     digit value zero
//   bcd_digit_t  one packed BCD digit
//   bcd_sanitise clamps an out-of-range digit code (10..15) to 9
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD digit of the down-counter (register plus decrement logic).
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset, clears the digit to 0
//   load     in   synchronous load, priority over dec
//   ld_d     in   raw preset digit; codes above 9 are clamped to 9
//   dec      in   decrement this digit on the next edge (0 wraps to 9)
//   q        out  current digit value, registered, always 0..9
//   is_zero  out  high while q == 0; feeds the borrow chain
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_d,
    input  logic             dec,
    output logic [BCD_W-1:0] q,
    output logic             is_zero
);

    bcd_digit_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_sanitise(ld_d);
        end else if (dec) begin
            q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q       = q_q;
    assign is_zero = (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable multi-digit BCD down-counter, digit 0 least significant.
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (out=0, load_err=0)
//   en        in   count enable, decrement by one per edge
//   load      in   synchronous load of load_val, priority over en
//   load_val  in   packed BCD preset, digit i at [4i+3:4i]
//   out       out  current count, packed BCD, registered
//   zero      out  high while out == 0
//   tc        out  terminal count en & zero & ~load (combinational, for cascading)
//   load_err  out  high for one cycle after a load containing a digit above 9
// Build option: define BCD_SATURATE_EN to hold at 0 instead of wrapping to all 9s.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   out,
    output logic                  zero,
    output logic                  tc,
    output logic                  load_err
);

    logic [DIGITS-1:0] dec;
    logic [DIGITS-1:0] dig_zero;
    logic [DIGITS-1:0] dig_bad;
    logic              dec_root;
    logic              load_err_q;

`ifdef BCD_SATURATE_EN
    // Blocking the root borrow at zero stops every digit, so the count sticks at 0.
    assign dec_root = en & ~load & ~zero;
`else
    assign dec_root = en & ~load;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        // Ripple borrow: a digit moves only when every lower digit is at 0.
        if (i == 0) begin : g_root
            assign dec[i] = dec_root;
        end else begin : g_chain
            assign dec[i] = dec[i-1] & dig_zero[i-1];
        end

        assign dig_bad[i] = (load_val[BCD_W*i +: BCD_W] > BCD_MAX);

        bcd_digit_down u_digit (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .ld_d    (load_val[BCD_W*i +: BCD_W]),
            .dec     (dec[i]),
            .q       (out[BCD_W*i +: BCD_W]),
            .is_zero (dig_zero[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load & (|dig_bad);
        end
    end

    assign zero     = &dig_zero;
    assign tc       = en & zero & ~load;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
module tb_bcd_down_counter;

    localparam int unsigned DIGITS = 2;

`ifdef BCD_SATURATE_EN
    localparam logic [7:0] WRAP_OUT = 8'h00;
`else
    localparam logic [7:0] WRAP_OUT = 8'h99;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] out;
    logic       zero;
    logic       tc;
    logic       load_err;

    int checks;
    int failures;

    bcd_down_counter #(
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .zero     (zero),
        .tc       (tc),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic [7:0] val;
        logic       exp_tc;   // tc before the edge
        logic [7:0] exp_out;  // out after the edge
        logic       exp_err;  // load_err after the edge
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a posedge: drive inputs, check tc, clock, check registers.
    task automatic step(input string name, input logic l, input logic e, input logic [7:0] v,
                        input logic exp_tc, input logic [7:0] exp_out, input logic exp_err);
        load     = l;
        en       = e;
        load_val = v;
        #1;
        chk({name, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
        @(posedge clk);
        #1;
        chk({name, ".out"}, {24'd0, out}, {24'd0, exp_out});
        chk({name, ".zero"}, {31'd0, zero}, {31'd0, (exp_out == 8'h00)});
        chk({name, ".load_err"}, {31'd0, load_err}, {31'd0, exp_err});
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    vec_t vecs[$];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;

        // Reset state.
        #12;
        chk("reset.out", {24'd0, out}, 32'h00);
        chk("reset.zero", {31'd0, zero}, 32'd1);
        chk("reset.load_err", {31'd0, load_err}, 32'd0);
        chk("reset.tc", {31'd0, tc}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //          load  en    val    tc    out    err
        vecs.push_back('{1'b1, 1'b0, 8'h42, 1'b0, 8'h42, 1'b0});   // plain load
        vecs.push_back('{1'b1, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0});   // load beats en
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h09, 1'b0});   // digit-1 borrow
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h08, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'hA5, 1'b0, 8'h95, 1'b1});   // invalid high digit
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h95, 1'b0});   // err lasts one cycle
        vecs.push_back('{1'b1, 1'b0, 8'h63, 1'b0, 8'h63, 1'b0});
        for (int i = 0; i < 5; i++) begin
            vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 8'h63, 1'b0}); // hold
        end
        vecs.push_back('{1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, WRAP_OUT, 1'b0}); // wrap / saturate
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 1'b0, 8'h99, 1'b1});   // both digits invalid
        vecs.push_back('{1'b1, 1'b0, 8'h3C, 1'b0, 8'h39, 1'b1});   // invalid low digit
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0});   // load masks tc at zero
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, WRAP_OUT, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b0, 8'h19, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].load, vecs[i].en, vecs[i].val,
                 vecs[i].exp_tc, vecs[i].exp_out, vecs[i].exp_err);
        end

        // Full countdown from 42 against an integer model.
        step("cd.load", 1'b1, 1'b0, 8'h42, 1'b0, 8'h42, 1'b0);
        for (int n = 41; n >= 0; n--) begin
            step($sformatf("cd%0d", n), 1'b0, 1'b1, 8'h00, 1'b0, to_bcd(n), 1'b0);
        end

        // Asynchronous reset mid-count at 37, between edges.
        step("mc.load", 1'b1, 1'b0, 8'h37, 1'b0, 8'h37, 1'b0);
        en   = 1'b1;
        load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.out", {24'd0, out}, 32'h00);
        chk("async_rst.zero", {31'd0, zero}, 32'd1);
        chk("async_rst.load_err", {31'd0, load_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.out", {24'd0, out}, 32'h00);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset while load_err is showing clears it at once.
        step("err.load", 1'b1, 1'b0, 8'hA5, 1'b0, 8'h95, 1'b1);
        load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("err_rst.load_err", {31'd0, load_err}, 32'd0);
        chk("err_rst.out", {24'd0, out}, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // First edge after reset release may count.
        step("post_rst.wrap", 1'b0, 1'b1, 8'h00, 1'b1, WRAP_OUT, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
